// File: rtl/lcd_text_driver.sv
// HD44780 16x2 text driver: power-up init, then continuous refresh of a
// 32-char buffer read through the index/char_in port of the mode blocks.
module lcd_text_driver #(
    parameter int unsigned PWRUP_CYC    = 750000,
    parameter int unsigned E_HIGH_CYC   = 25,
    parameter int unsigned CMD_WAIT_CYC = 2500,
    parameter int unsigned CLR_WAIT_CYC = 100000,
    parameter int unsigned FETCH_LAT    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);

    typedef enum logic [2:0] {PWR_WAIT, SETUP, PULSE, HOLD, FETCH} state_t;
    typedef enum logic [1:0] {K_INIT, K_ADDR, K_CHAR} kind_t;

    localparam logic [19:0] PWRUP_LAST = 20'(PWRUP_CYC - 1);
    localparam logic [19:0] E_LAST     = 20'(E_HIGH_CYC - 1);
    localparam logic [19:0] CMD_LAST   = 20'(CMD_WAIT_CYC - 1);
    localparam logic [19:0] CLR_LAST   = 20'(CLR_WAIT_CYC - 1);
    localparam logic [19:0] FETCH_LAST = 20'(FETCH_LAT - 1);

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [1:0]  step_q, step_d;
    logic [19:0] cnt_q, cnt_d;
    logic [4:0]  index_q, index_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        init_done_q, init_done_d;
    logic        frame_done_q, frame_done_d;
    logic [19:0] hold_last;

    function automatic logic [7:0] init_cmd(input logic [1:0] s);
        case (s)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= PWR_WAIT;
            kind_q       <= K_INIT;
            step_q       <= '0;
            cnt_q        <= '0;
            index_q      <= '0;
            data_q       <= '0;
            rs_q         <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            index_q      <= index_d;
            data_q       <= data_d;
            rs_q         <= rs_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Only the clear command needs the long settle time.
    assign hold_last = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        step_d       = step_q;
        cnt_d        = cnt_q + 20'd1;
        index_d      = index_q;
        data_d       = data_q;
        rs_d         = rs_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == PWRUP_LAST) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    kind_d  = K_INIT;
                    step_d  = '0;
                    data_d  = init_cmd(2'd0);
                    rs_d    = 1'b0;
                end
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = '0;
            end
            PULSE: begin
                if (cnt_q == E_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == hold_last) begin
                    cnt_d = '0;
                    case (kind_q)
                        K_INIT: begin
                            state_d = SETUP;
                            rs_d    = 1'b0;
                            if (step_q == 2'd3) begin
                                init_done_d = 1'b1;
                                kind_d      = K_ADDR;
                                data_d      = (index_q == 5'd0) ? 8'h80 : 8'hC0;
                            end else begin
                                step_d = step_q + 2'd1;
                                data_d = init_cmd(step_q + 2'd1);
                            end
                        end
                        K_ADDR: begin
                            state_d = FETCH;
                            kind_d  = K_CHAR;
                        end
                        default: begin
                            // Line ends re-address the cursor; others stream on.
                            if (index_q == 5'd15 || index_q == 5'd31) begin
                                state_d = SETUP;
                                kind_d  = K_ADDR;
                                rs_d    = 1'b0;
                                if (index_q == 5'd15) begin
                                    index_d = 5'd16;
                                    data_d  = 8'hC0;
                                end else begin
                                    index_d      = 5'd0;
                                    data_d       = 8'h80;
                                    frame_done_d = 1'b1;
                                end
                            end else begin
                                state_d = FETCH;
                                index_d = index_q + 5'd1;
                            end
                        end
                    endcase
                end
            end
            FETCH: begin
                if (cnt_q == FETCH_LAST) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    data_d  = char_in;
                    rs_d    = 1'b1;
                end
            end
            default: begin
                state_d = PWR_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        index      = index_q;
        lcd_rs     = rs_q;
        lcd_rw     = 1'b0;
        lcd_e      = (state_q == PULSE);
        lcd_data   = data_q;
        init_done  = init_done_q;
        frame_done = frame_done_q;
    end

endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed bench for lcd_text_driver with short timing parameters and a
// registered char source returning 0x41 + index.
module tb_lcd_text_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic [4:0] index;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;
    logic       init_done, frame_done;

    int total = 0;
    int bad   = 0;
    bit mod5  = 1'b0;

    always #5 clk = ~clk;

    lcd_text_driver #(
        .PWRUP_CYC(10),
        .E_HIGH_CYC(2),
        .CMD_WAIT_CYC(4),
        .CLR_WAIT_CYC(8),
        .FETCH_LAT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .char_in(char_in),
        .index(index),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw),
        .lcd_e(lcd_e),
        .lcd_data(lcd_data),
        .init_done(init_done),
        .frame_done(frame_done)
    );

    // Char source: answers one clock after index changes.
    always @(posedge clk)
        char_in <= (mod5 && index == 5'd5) ? 8'h7A : 8'h41 + {3'b000, index};

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         gap;
        logic [4:0] idx;
        logic       idone;
    } wr_t;

    wr_t  wq[$];
    logic e_prev = 1'b0, rs_prev = 1'b0, idone_prev = 1'b0;
    logic [7:0] d_prev = 8'h00;
    int hold_left = 0, hi_len = 0, low_len = 0;
    int viol = 0, hi_bad = 0, fd_hi = 0, idone_at_low = -1;

    // Bus monitor: logs each write at its lcd_e rise and tallies timing faults.
    always @(negedge clk) begin
        if (!rst) begin
            e_prev = 1'b0; rs_prev = 1'b0; d_prev = 8'h00; idone_prev = 1'b0;
            hold_left = 0; hi_len = 0; low_len = 0; idone_at_low = -1;
        end else begin
            if ((lcd_e || e_prev || hold_left > 0) &&
                (lcd_data !== d_prev || lcd_rs !== rs_prev))
                viol++;
            if (frame_done) fd_hi++;
            if (lcd_e) begin
                if (!e_prev) wq.push_back('{lcd_data, lcd_rs, low_len, index, init_done});
                hi_len++;
                low_len = 0;
                hold_left = (!lcd_rs && lcd_data == 8'h01) ? 8 : 4;
            end else begin
                if (e_prev) begin
                    if (hi_len != 2) hi_bad++;
                    hi_len = 0;
                end
                low_len++;
                if (hold_left > 0) hold_left--;
            end
            if (init_done && !idone_prev) idone_at_low = low_len;
            e_prev = lcd_e; d_prev = lcd_data; rs_prev = lcd_rs; idone_prev = init_done;
        end
    end

    task automatic get_write(output wr_t w, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (wq.size() == 0 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        if (wq.size() != 0) begin
            w  = wq.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic wait_init_done(output bit ok);
        int n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        ok = (init_done === 1'b1);
    endtask

    task automatic test_reset;
        int early = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({index, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got idx=%0d rs=%b rw=%b e=%b data=%h idone=%b fdone=%b exp all 0",
                     index, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done);
        end
        rst = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk); #1;
            if (lcd_e !== 1'b0 || lcd_data !== 8'h00) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL pwrup_quiet got %0d busy samples exp 0", early);
        end
        @(negedge clk); #1;
        total++;
        if (lcd_e !== 1'b0 || lcd_data !== 8'h38 || lcd_rs !== 1'b0) begin
            bad++;
            $display("FAIL first_setup got e=%b data=%h rs=%b exp e=0 data=38 rs=0", lcd_e, lcd_data, lcd_rs);
        end
    endtask

    task automatic test_init(input string tag);
        logic [7:0] cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
        wr_t w;
        bit  ok;
        for (int i = 0; i < 4; i++) begin
            get_write(w, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s_timeout write %0d got none exp %h", tag, i, cmds[i]);
                return;
            end
            if (w.data !== cmds[i] || w.rs !== 1'b0 || w.gap != (i == 0 ? 10 : 5) || w.idone !== 1'b0) begin
                bad++;
                $display("FAIL %s_cmd%0d got data=%h rs=%b gap=%0d idone=%b exp data=%h rs=0 gap=%0d idone=0",
                         tag, i, w.data, w.rs, w.gap, w.idone, cmds[i], (i == 0 ? 10 : 5));
            end
        end
        wait_init_done(ok);
        total++;
        if (!ok || idone_at_low != 9) begin
            bad++;
            $display("FAIL %s_init_done got done=%b at_low=%0d exp done=1 at_low=9", tag, init_done, idone_at_low);
        end
    endtask

    // Checks writes k_first..33 of one frame; k=0 is 0x80, k=17 is 0xC0.
    task automatic check_frame(input string tag, input int k_first, input int gap0, input bit set_mod);
        wr_t w;
        bit  ok;
        logic [7:0] ed;
        logic       er;
        logic [4:0] ei;
        int c, eg;
        for (int k = k_first; k < 34; k++) begin
            get_write(w, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s_timeout write %0d", tag, k);
                return;
            end
            if (k == 0) begin
                ed = 8'h80; er = 1'b0; ei = 5'd0; eg = gap0;
            end else if (k == 17) begin
                ed = 8'hC0; er = 1'b0; ei = 5'd16; eg = 5;
            end else begin
                c  = (k < 17) ? k - 1 : k - 2;
                ei = 5'(c);
                ed = (mod5 && !set_mod && c == 5) ? 8'h7A : 8'(8'h41 + c);
                er = 1'b1;
                eg = 7;
            end
            if (w.data !== ed || w.rs !== er || w.idx !== ei || w.gap != eg) begin
                bad++;
                $display("FAIL %s k=%0d got data=%h rs=%b idx=%0d gap=%0d exp data=%h rs=%b idx=%0d gap=%0d",
                         tag, k, w.data, w.rs, w.idx, w.gap, ed, er, ei, eg);
            end
            if (set_mod && er && ei == 5'd5) mod5 = 1'b1;
        end
    endtask

    task automatic test_frame;
        wr_t w;
        bit  ok;
        check_frame("frame1", 0, 9, 1'b1);
        total++;
        if (fd_hi != 0) begin
            bad++;
            $display("FAIL frame_done_early got %0d exp 0", fd_hi);
        end
        get_write(w, ok);
        total++;
        if (!ok || w.data !== 8'h80 || w.rs !== 1'b0 || w.idx !== 5'd0 || w.gap != 5) begin
            bad++;
            $display("FAIL frame_wrap got ok=%b data=%h rs=%b idx=%0d gap=%0d exp data=80 rs=0 idx=0 gap=5",
                     ok, w.data, w.rs, w.idx, w.gap);
        end
        total++;
        if (fd_hi != 1) begin
            bad++;
            $display("FAIL frame_done_pulse got %0d high clks exp 1", fd_hi);
        end
    endtask

    task automatic test_char_change;
        check_frame("frame2", 1, 5, 1'b0);
    endtask

    task automatic test_reset_mid;
        wr_t w;
        bit  ok;
        bit  found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            get_write(w, ok);
            if (ok && w.rs === 1'b1 && w.idx === 5'd20) found = 1'b1;
        end
        total++;
        if (!found || lcd_e !== 1'b1) begin
            bad++;
            $display("FAIL mid_pulse_reach got found=%b e=%b exp found=1 e=1", found, lcd_e);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (lcd_e !== 1'b0 || index !== 5'd0 || init_done !== 1'b0 || lcd_data !== 8'h00 || lcd_rs !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got e=%b idx=%0d idone=%b data=%h rs=%b exp all 0",
                     lcd_e, index, init_done, lcd_data, lcd_rs);
        end
        @(negedge clk); #1;
        wq.delete();
        rst = 1'b1;
        test_init("reinit");
    endtask

    task automatic test_timing;
        check_frame("frame_reinit", 0, 9, 1'b0);
        total++;
        if (hi_bad != 0) begin
            bad++;
            $display("FAIL e_high_len got %0d bad pulses exp 0", hi_bad);
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL bus_stability got %0d changes exp 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_init("init");
        test_frame();
        test_char_change();
        test_reset_mid();
        test_timing();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish exp finish before 2ms");
        $fatal(1, "watchdog");
    end

endmodule
